// File: rtl/kan_tda_mem_pkg.sv
// kan_tda_mem_pkg: shared L3 arbiter state type, requester index map and L3 geometry.
package kan_tda_mem_pkg;
    typedef enum logic {IDLE, BURST} arb_state_e;
    localparam int NUM_KAN    = 16;
    localparam int NUM_TDA    = 4;
    localparam int KAN_BASE   = 0;
    localparam int TDA_BASE   = KAN_BASE + NUM_KAN;
    localparam int NUM_L3_REQ = TDA_BASE + NUM_TDA;
    localparam int L3_DATA_W  = 16;
    localparam int L3_ADDR_W  = 12;
endpackage

// File: rtl/l3_port_arbiter_if.sv
// l3_port_arbiter_if: requester/L3 bundle; slave = arbiter, master = requesters plus L3 macro.
// Optional perf counters appear when L3_ARB_PERF_CNT_EN is defined.
interface l3_port_arbiter_if
    import kan_tda_mem_pkg::*;
#(
    parameter int NUM_REQ    = NUM_L3_REQ,
    parameter int DATA_WIDTH = L3_DATA_W,
    parameter int ADDR_WIDTH = L3_ADDR_W,
    parameter int MAX_BURST  = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int LEN_WIDTH  = $clog2(MAX_BURST)
);
    logic [NUM_REQ-1:0]            req, req_mask, req_we, gnt;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic                          rvalid, busy, mem_en, mem_we;
    logic [ID_WIDTH-1:0]           rid;
    logic [DATA_WIDTH-1:0]         rdata, mem_wdata, mem_rdata;
    logic [ADDR_WIDTH-1:0]         mem_addr;
`ifdef L3_ARB_PERF_CNT_EN
    logic [31:0]                   perf_beats, perf_conflicts;
`endif
    modport slave (
        input  req, req_mask, req_we, req_addr, req_len, req_wdata, mem_rdata,
        output gnt, rvalid, rid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
`ifdef L3_ARB_PERF_CNT_EN
        , output perf_beats, perf_conflicts
`endif
    );
    modport master (
        output req, req_mask, req_we, req_addr, req_len, req_wdata, mem_rdata,
        input  gnt, rvalid, rid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
`ifdef L3_ARB_PERF_CNT_EN
        , input perf_beats, perf_conflicts
`endif
    );
endinterface

// File: rtl/l3_port_arbiter_rr_pick.sv
// rr_pick: first set bit of eligible at or after rr_ptr, searching upward and wrapping at N.
module rr_pick #(
    parameter int N = 20,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] rr_ptr,
    output logic         valid,
    output logic [W-1:0] index
);
    always_comb begin
        valid = |eligible;
        index = '0;
        // Scan farthest-first so the nearest eligible index is the last write.
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr) + k) % N]) index = W'((int'(rr_ptr) + k) % N);
        end
    end
endmodule

// File: rtl/l3_port_arbiter.sv
// l3_port_arbiter: round-robin L3 port arbiter and burst sequencer with owner-tagged read return.
// Define L3_ARB_PERF_CNT_EN to add the saturating perf_beats/perf_conflicts counters.
module l3_port_arbiter
    import kan_tda_mem_pkg::*;
#(
    parameter int NUM_REQ    = NUM_L3_REQ,
    parameter int DATA_WIDTH = L3_DATA_W,
    parameter int ADDR_WIDTH = L3_ADDR_W,
    parameter int MAX_BURST  = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
    input logic              clk,
    input logic              rst,
    l3_port_arbiter_if.slave bus
);
    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    eligible, gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d, rr_q, rr_d, rid_q, rid_d, pick_idx;
    logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  pick_valid, we_q, we_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic                  rvalid_q, rvalid_d;

    assign eligible = bus.req & bus.req_mask;

    rr_pick #(.N(NUM_REQ), .W(ID_WIDTH)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_q),
        .valid    (pick_valid),
        .index    (pick_idx)
    );

    // Outputs are registered: the decision taken at an edge is the beat issued in the next cycle.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        len_d      = len_q;
        we_d       = we_q;
        beat_d     = beat_q;
        rr_d       = rr_q;
        gnt_d      = '0;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rvalid_d   = mem_en_q & ~mem_we_q;
        rid_d      = rvalid_d ? owner_q : rid_q;
        if (state_q == IDLE) begin
            if (pick_valid) begin
                state_d    = BURST;
                owner_d    = pick_idx;
                len_d      = bus.req_len[pick_idx*LEN_WIDTH +: LEN_WIDTH];
                we_d       = bus.req_we[pick_idx];
                beat_d     = '0;
                gnt_d      = NUM_REQ'(1) << pick_idx;
                mem_en_d   = 1'b1;
                mem_we_d   = bus.req_we[pick_idx];
                mem_addr_d = bus.req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end else if (beat_q == len_q || !eligible[owner_q]) begin
            state_d = IDLE;
            rr_d    = (owner_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner_q + ID_WIDTH'(1);
        end else begin
            beat_d     = beat_q + LEN_WIDTH'(1);
            gnt_d      = NUM_REQ'(1) << owner_q;
            mem_en_d   = 1'b1;
            mem_we_d   = we_q;
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            beat_q     <= '0;
            rr_q       <= '0;
            gnt_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            len_q      <= len_d;
            we_q       <= we_d;
            beat_q     <= beat_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == BURST);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = bus.req_wdata[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign bus.rvalid    = rvalid_q;
    assign bus.rid       = rid_q;
    assign bus.rdata     = bus.mem_rdata;

`ifdef L3_ARB_PERF_CNT_EN
    logic [31:0] perf_beats_q, perf_beats_d, perf_conf_q, perf_conf_d;
    logic        multi_elig;

    assign multi_elig = (eligible & (eligible - NUM_REQ'(1))) != '0;

    always_comb begin
        perf_beats_d = perf_beats_q + 32'(mem_en_q && !(&perf_beats_q));
        perf_conf_d  = perf_conf_q + 32'(state_q == IDLE && multi_elig && !(&perf_conf_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats_q <= '0;
            perf_conf_q  <= '0;
        end else begin
            perf_beats_q <= perf_beats_d;
            perf_conf_q  <= perf_conf_d;
        end
    end

    assign bus.perf_beats     = perf_beats_q;
    assign bus.perf_conflicts = perf_conf_q;
`endif
endmodule

// File: tb/tb_l3_port_arbiter.sv
// tb_l3_port_arbiter: directed and random stimulus against a cycle-level behavioural model of the arbiter.
module tb_l3_port_arbiter;
    localparam int N = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l3_port_arbiter_if bus ();
    l3_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [N-1:0] req = '0, mask = '1, we = '0;
    logic [11:0]  addr  [N];
    logic [2:0]   len   [N];
    logic [15:0]  wbase [N];
    logic [15:0]  wcnt  [N];
    logic [15:0]  mem   [4096];
    logic [15:0]  mmem  [4096];

    always_comb begin
        bus.req      = req;
        bus.req_mask = mask;
        bus.req_we   = we;
        bus.req_addr = '0;
        bus.req_len  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*12 +: 12]  = addr[i];
            bus.req_len[i*3 +: 3]     = len[i];
            bus.req_wdata[i*16 +: 16] = wbase[i] + wcnt[i];
        end
    end

    int checks = 0, errors = 0;
    bit armed = 0;
    // Model: cur = requester issuing a beat this cycle (-1 none), left = beats still to go after this one.
    int cur = -1, rr_m = 0, left = 0, maddr = 0, raddr = 0, rid_m = 0, pb = 0, pc = 0;
    bit mwe = 0, rv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic compare();
        chk("gnt", 32'(bus.gnt), cur >= 0 ? 32'(1) << cur : 32'(0));
        chk("busy", 32'(bus.busy), 32'(cur >= 0));
        chk("mem_en", 32'(bus.mem_en), 32'(cur >= 0));
        chk("mem_we", 32'(bus.mem_we), 32'(cur >= 0 && mwe));
        if (cur >= 0) chk("mem_addr", 32'(bus.mem_addr), 32'(maddr));
        if (cur >= 0 && mwe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(16'(wbase[cur] + wcnt[cur])));
        chk("rvalid", 32'(bus.rvalid), 32'(rv));
        chk("rid", 32'(bus.rid), 32'(rid_m));
        if (rv) chk("rdata", 32'(bus.rdata), 32'(mmem[raddr]));
`ifdef L3_ARB_PERF_CNT_EN
        chk("perf_beats", bus.perf_beats, 32'(pb));
        chk("perf_conflicts", bus.perf_conflicts, 32'(pc));
`endif
    endtask

    task automatic model_update(input logic [N-1:0] el, input logic r);
        if (r) begin
            cur = -1; rr_m = 0; rv = 0; rid_m = 0; pb = 0; pc = 0;
        end else begin
            pb += int'(cur >= 0);
            pc += int'(cur < 0 && $countones(el) > 1);
            rv = (cur >= 0 && !mwe);
            if (rv) begin rid_m = cur; raddr = maddr; end
            if (cur >= 0 && mwe) mmem[maddr] = wbase[cur] + wcnt[cur];
            if (cur >= 0) begin
                if (left == 0 || !el[cur]) begin rr_m = (cur + 1) % N; cur = -1; end
                else begin left--; maddr = (maddr + 1) % 4096; end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (cur < 0 && el[(rr_m + k) % N]) begin
                        cur = (rr_m + k) % N;
                        maddr = int'(addr[cur]); left = int'(len[cur]); mwe = we[cur];
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] gp, el;
        logic en, w, r;
        logic [11:0] a;
        logic [15:0] wd;
        #2;
        if (armed) compare();
        gp = bus.gnt; el = req & mask; r = rst;
        en = bus.mem_en; w = bus.mem_we; a = bus.mem_addr; wd = bus.mem_wdata;
        @(posedge clk);
        #1;
        if (en && w) mem[a] = wd;
        if (en && !w) bus.mem_rdata = mem[a];
        model_update(el, r);
        for (int i = 0; i < N; i++) if (gp[i]) wcnt[i]++;
        if (r) armed = 1;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    task automatic wait_gnt(output int who);
        who = -1;
        for (int c = 0; c < 40; c++) begin
            if (bus.gnt != '0) begin who = idx_of(bus.gnt); return; end
            step();
        end
    endtask

    task automatic set_req(input int i, input logic [11:0] a, input logic [2:0] l, input logic w);
        addr[i] = a; len[i] = l; we[i] = w; req[i] = 1'b1;
    endtask

    initial begin
        int who, n;
        int got[4], at[4];
        bus.mem_rdata = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = '0; len[i] = '0; wcnt[i] = '0; wbase[i] = 16'($urandom);
        end
        for (int i = 0; i < 4096; i++) begin mem[i] = 16'($urandom); mmem[i] = mem[i]; end
        do_reset();
        chk("reset_gnt", 32'(bus.gnt), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_mem_en", 32'(bus.mem_en), 0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 0);
        chk("reset_rvalid", 32'(bus.rvalid), 0);

        // single read burst
        set_req(3, 12'h100, 3'd3, 1'b0);
        step();
        for (int b = 0; b < 4; b++) begin
            chk("rd_gnt", 32'(bus.gnt), 32'h8);
            chk("rd_addr", 32'(bus.mem_addr), 32'h100 + 32'(b));
            if (b == 3) req[3] = 1'b0;
            step();
            chk("rd_rvalid", 32'(bus.rvalid), 1);
            chk("rd_rid", 32'(bus.rid), 3);
        end
        chk("rd_done", 32'(bus.gnt), 0);

        // round robin 0,5,19
        do_reset();
        set_req(0, 12'h010, 3'd0, 1'b0); set_req(5, 12'h050, 3'd0, 1'b0); set_req(19, 12'h190, 3'd0, 1'b0);
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            step();
            if (bus.gnt != '0) begin got[n] = idx_of(bus.gnt); at[n] = c; n++; end
        end
        chk("rr_count", 32'(n), 4);
        chk("rr_0", 32'(got[0]), 0);
        chk("rr_1", 32'(got[1]), 5);
        chk("rr_2", 32'(got[2]), 19);
        chk("rr_3", 32'(got[3]), 0);
        for (int k = 1; k < 4; k++) chk("rr_gap", 32'(at[k] - at[k-1]), 2);
        req = '0; step(); step();
        req[5] = 1'b1; wait_gnt(who); chk("rr_5", 32'(who), 5);
        req[5] = 1'b0; step();
        req[0] = 1'b1; req[19] = 1'b1;
        wait_gnt(who); chk("rr_from6", 32'(who), 19);
        req = '0; step(); step();

        // write burst wrapping the address space
        wcnt[17] = '0; wbase[17] = 16'h00A0;
        set_req(17, 12'hFFE, 3'd3, 1'b1);
        wait_gnt(who); chk("wr_owner", 32'(who), 17);
        for (int b = 0; b < 4; b++) begin if (b == 3) req[17] = 1'b0; step(); end
        chk("wr_ffe", 32'(mem[12'hFFE]), 32'hA0);
        chk("wr_fff", 32'(mem[12'hFFF]), 32'hA1);
        chk("wr_000", 32'(mem[12'h000]), 32'hA2);
        chk("wr_001", 32'(mem[12'h001]), 32'hA3);

        // masked requester
        mask[2] = 1'b0; set_req(2, 12'h020, 3'd1, 1'b0);
        n = 0;
        for (int c = 0; c < 20; c++) begin step(); if (bus.gnt[2]) n++; end
        chk("mask_never", 32'(n), 0);
        req[2] = 1'b0; mask[2] = 1'b1; step();

        // abort by dropping the owner's mask
        set_req(4, 12'h200, 3'd7, 1'b0); set_req(6, 12'h300, 3'd0, 1'b0);
        wait_gnt(who); chk("ab_owner", 32'(who), 4);
        step(); chk("ab_beat2", 32'(bus.gnt), 32'h10);
        mask[4] = 1'b0;
        step(); chk("ab_bubble", 32'(bus.gnt), 0);
        step(); chk("ab_next", 32'(bus.gnt), 32'h40);
        req[4] = 1'b0; req[6] = 1'b0; mask[4] = 1'b1; step(); step();

        // reset in the middle of a read burst
        set_req(7, 12'h400, 3'd5, 1'b0);
        wait_gnt(who); chk("rs_owner", 32'(who), 7);
        step();
        rst = 1'b1; step();
        chk("rs_gnt", 32'(bus.gnt), 0);
        chk("rs_busy", 32'(bus.busy), 0);
        chk("rs_mem_en", 32'(bus.mem_en), 0);
        chk("rs_rvalid", 32'(bus.rvalid), 0);
        rst = 1'b0; req[7] = 1'b0; step();
        chk("rs_rvalid2", 32'(bus.rvalid), 0);
        set_req(1, 12'h011, 3'd0, 1'b0); set_req(9, 12'h099, 3'd0, 1'b0);
        wait_gnt(who); chk("rs_rr0", 32'(who), 1);
        req = '0; step(); step();

`ifdef L3_ARB_PERF_CNT_EN
        do_reset();
        set_req(10, 12'h0A0, 3'd1, 1'b0); set_req(11, 12'h0B0, 3'd1, 1'b0);
        wait_gnt(who); chk("pf_first", 32'(who), 10);
        step(); req[10] = 1'b0; step();
        wait_gnt(who); chk("pf_second", 32'(who), 11);
        step(); req[11] = 1'b0; step();
        chk("pf_beats", bus.perf_beats, 4);
        chk("pf_conflicts", bus.perf_conflicts, 1);
`endif

        // random traffic
        req = '0; mask = '1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) req[i] = ~req[i];
                if ($urandom_range(63) == 0) mask[i] = ~mask[i];
                if (!req[i]) begin
                    addr[i] = 12'($urandom); len[i] = 3'($urandom); we[i] = 1'($urandom);
                end
            end
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0; req = '0; step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l3_port_arbiter.md
Name: l3_port_arbiter

Overview:
- Round-robin arbiter and burst sequencer for the single-port on-chip L3 cache shared by the 16 KAN cores and 4 TDA units in the accelerator top level.
- Grants one requester at a time and generates per-beat L3 address, write-enable and write data for bursts of up to MAX_BURST words.
- Returns read data tagged with the owner ID.
- Masks requesters whose power domain is inactive.

Parameters:
- NUM_REQ, 20, number of requesters (16 KAN, then 4 TDA, index order).
- DATA_WIDTH, 16, L3 word width.
- ADDR_WIDTH, 12, L3 word address width.
- MAX_BURST, 8, maximum beats per grant (power of two).
- ID_WIDTH, $clog2(NUM_REQ), owner-ID width.
- LEN_WIDTH, $clog2(MAX_BURST), burst-length field width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester access request.
- req_mask  in  NUM_REQ  1 = requester's domain active; 0 = ignore its req.
- req_we  in  NUM_REQ  1 = write burst.
- req_addr  in  NUM_REQ*ADDR_WIDTH  burst base address, flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_len  in  NUM_REQ*LEN_WIDTH  beats minus one, flattened.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data for the current beat, flattened.
- gnt  out  NUM_REQ  one-hot; high on each cycle a beat of requester i is issued.
- rvalid  out  1  read data valid.
- rid  out  ID_WIDTH  owner of rdata.
- rdata  out  DATA_WIDTH  read data.
- busy  out  1  burst in progress.
- mem_en  out  1  L3 access this cycle.
- mem_we  out  1  L3 write.
- mem_addr  out  ADDR_WIDTH  L3 address.
- mem_wdata  out  DATA_WIDTH  L3 write data.
- mem_rdata  in  DATA_WIDTH  L3 read data, valid one cycle after a read mem_en.

Behaviour:
- Reset values: gnt=0, rvalid=0, rid=0, busy=0, mem_en=0, mem_we=0, mem_addr=0. rr_ptr=0; state=IDLE.
- Eligibility: eligible[i] = req[i] & req_mask[i].
- IDLE state:
  - If any requester is eligible, select the first eligible index at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - Latch owner, base address, length and we, then go to BURST.
  - Otherwise stay in IDLE.
- BURST state, one beat per cycle:
  - gnt[owner]=1, mem_en=1, mem_we=latched we.
  - mem_addr = base + beat, wrapping modulo 2^ADDR_WIDTH.
  - mem_wdata = req_wdata[owner]. The requester advances its wdata on each cycle where gnt is high.
  - After beat == len: go to IDLE and set rr_ptr = owner+1, wrapping NUM_REQ-1 -> 0.
  - Early termination: if eligible[owner] drops, issue no further beats, update rr_ptr the same way, and go to IDLE.
- Latency:
  - req to first gnt is 1 cycle.
  - There is exactly one IDLE bubble between consecutive bursts.
  - Burst duration is len+1 cycles.
- Read return:
  - rvalid is high the cycle after each read beat.
  - rdata = mem_rdata and rid = owner of that beat. These are registered, so they hold across a burst change.
- busy = (state==BURST).
- Only one gnt bit is ever high. mem_en is never high in IDLE.
- A change to another requester's req during a burst has no effect until IDLE.
- Reset mid-burst:
  - Abort the burst and clear all outputs on the next edge.
  - A read beat in flight produces no rvalid.

Optional Feature:
- Macro L3_ARB_PERF_CNT_EN.
- With the macro defined:
  - Add output perf_beats (32-bit, count of mem_en cycles).
  - Add output perf_conflicts (32-bit, count of IDLE cycles where more than one requester is eligible).
  - Both saturate at all-ones and reset to 0.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package kan_tda_mem_pkg holds:
  - the state enum (IDLE, BURST);
  - the KAN/TDA requester index base constants (KAN_BASE=0, TDA_BASE=16);
  - the L3 word width and address width constants.
- One sub-module, rr_pick: a combinational round-robin priority encoder with inputs eligible and rr_ptr, and outputs valid and index.

Test Plan:
- Single read: req[3]=1, addr 0x100, len 3, we=0.
  - gnt[3] is high for 4 cycles starting 1 cycle after req.
  - mem_addr goes 0x100..0x103.
  - rvalid is high for 4 cycles, each with rid=3.
- Round robin: req[0], req[5] and req[19] held high with len 0.
  - Grant order is 0, 5, 19, 0, with one bubble between each.
  - With rr_ptr starting at 6, the first grant goes to 19.
- Write wrap: req[17] write, addr 0xFFE, len 3, wdata 0xA0..0xA3.
  - Writes go to addresses 0xFFE, 0xFFF, 0x000, 0x001 with the matching data.
- Mask and abort:
  - req[2] with req_mask[2]=0 is never granted.
  - Dropping req_mask[4] after the 2nd of 8 beats stops the burst after 2 beats; the next requester is granted after one bubble.
- Reset mid-burst: assert rst on read beat 2.
  - On the next cycle gnt=0, busy=0 and mem_en=0.
  - No rvalid is produced.
  - After rst is released, rr_ptr restarts at 0.
- Perf counters (only when L3_ARB_PERF_CNT_EN is defined): two simultaneous len-1 requests.
  - perf_beats = 4.
  - perf_conflicts = 1.
